// File: rtl/sha3_pad.sv
// sha3_pad: packs 32-bit message words into r-bit rate blocks and applies SHA-3 multi-rate padding.
// Define SHA3_PAD_SHAKE_EN to add the xof input selecting the SHAKE domain suffix (0x1F).
module sha3_pad #(
    parameter int d = 112,
    parameter int b = 1600
) (
    input  logic             clk,
    input  logic             reset,
`ifdef SHA3_PAD_SHAKE_EN
    input  logic             xof,
`endif
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [2:0]       in_bytes,
    output logic [b-2*d-1:0] block,
    output logic             block_valid,
    input  logic             block_ready,
    output logic             block_last
);
    localparam int R  = b - 2*d;
    localparam int NW = R / 32;
    localparam int NB = R / 8;
    localparam int WW = (NW > 1) ? $clog2(NW) : 1;
    localparam int PW = $clog2(NB + 1);

    if (R <= 0 || R % 32 != 0) begin : g_rate_check
        $error("sha3_pad: rate b-2*d must be a positive multiple of 32");
    end

    typedef enum logic [1:0] {FILL, PAD, EMIT} state_t;

    state_t        state, state_next;
    logic [R-1:0]  block_next;
    logic [WW-1:0] wcnt;
    logic [PW-1:0] pad_pos;
    logic          pad_pending;
    logic [2:0]    in_len;
    logic          accept, handoff, slot_end, fills_block;
    logic [7:0]    suffix;

    assign in_ready    = (state == FILL) && !reset;
    assign block_valid = (state == EMIT);
    assign accept      = in_valid && in_ready;
    assign handoff     = block_valid && block_ready;
    assign in_len      = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    assign slot_end    = (wcnt == WW'(NW - 1));
    // A last word that completes the block is emitted as data first; padding follows in its own block.
    assign fills_block = slot_end && (!in_last || in_len == 3'd4);

    always_comb begin
        state_next = state;
        case (state)
            FILL: begin
                if (accept) begin
                    if (fills_block)  state_next = EMIT;
                    else if (in_last) state_next = PAD;
                end
            end
            PAD:     state_next = EMIT;
            EMIT: begin
                if (handoff) state_next = pad_pending ? PAD : FILL;
            end
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        block_next = block;
        case (state)
            FILL: begin
                if (accept) begin
                    for (int unsigned k = 0; k < NB; k++) begin
                        if (k / 4 == 32'(wcnt) && (!in_last || k % 4 < 32'(in_len)))
                            block_next[R-1-8*k -: 8] = in_data[31-8*(k%4) -: 8];
                    end
                end
            end
            PAD: begin
                for (int unsigned k = 0; k < NB; k++) begin
                    if (k == 32'(pad_pos))
                        block_next[R-1-8*k -: 8] = block[R-1-8*k -: 8] ^ suffix;
                end
                block_next[7:0] = block_next[7:0] ^ 8'h80;
            end
            EMIT: begin
                if (handoff) block_next = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FILL;
            block       <= '0;
            wcnt        <= '0;
            pad_pos     <= '0;
            pad_pending <= 1'b0;
            block_last  <= 1'b0;
        end else begin
            state <= state_next;
            block <= block_next;
            if (handoff)
                wcnt <= '0;
            else if (accept && !slot_end)
                wcnt <= wcnt + 1'b1;
            if (accept && in_last) begin
                pad_pos     <= fills_block ? '0 : PW'({wcnt, 2'b00}) + PW'(in_len);
                pad_pending <= fills_block;
            end else if (handoff) begin
                pad_pending <= 1'b0;
            end
            if (state == PAD)
                block_last <= 1'b1;
            else if (handoff)
                block_last <= 1'b0;
        end
    end

`ifdef SHA3_PAD_SHAKE_EN
    logic msg_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            msg_start <= 1'b1;
            suffix    <= 8'h06;
        end else if (accept) begin
            msg_start <= in_last;
            if (msg_start) suffix <= xof ? 8'h1F : 8'h06;
        end
    end
`else
    assign suffix = 8'h06;
`endif

endmodule
